ex_mem_skid_reg: RTL and testbench
==================================

# ex_mem_skid_reg

Parametrised EX→MEM pipeline register for the multicycle MIPS datapath. It replaces the bare stage latch with a two-entry skid buffer that uses valid/ready handshakes on both sides. A synchronous flush kills in-flight instructions. Control bits are gated so a bubble can never write the register file or read memory.

## Interface
- `DATA_W`, default 32: width of `alu_result` and `mem_read_value`.
- `DEST_W`, default 5: width of the destination register index.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill every held entry; takes priority over all other inputs.
- `in_valid`  in  1  EX presents a beat.
- `in_ready`  out  1  stage can accept a beat; this is a registered output.
- `in_wb_en`, `in_mem_r_en`  in  1 each  control bits.
- `in_alu_result`, `in_mem_read_value`  in  DATA_W each  data payload.
- `in_dest`  in  DEST_W  destination register.
- `out_valid`  out  1  MEM side holds a beat.
- `out_ready`  in  1  MEM consumes the beat.
- `out_wb_en`, `out_mem_r_en`  out  1 each  stored control bits ANDed with `out_valid`.
- `out_alu_result`, `out_mem_read_value`  out  DATA_W each  data of the head entry.
- `out_dest`  out  DEST_W  destination of the head entry.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Storage: a main entry drives the outputs, plus one skid entry. Each entry holds `{wb_en, mem_r_en, alu_result, mem_read_value, dest}`.
- An input beat is accepted when `in_valid & in_ready`. An output beat is consumed when `out_valid & out_ready`.
- State machine with three states:
  - EMPTY: `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - ONE: `out_valid`=1, `in_ready`=1, `occupancy`=1.
  - FULL: `out_valid`=1, `in_ready`=0, `occupancy`=2.
- Transitions when `flush`=0:
  - From EMPTY: an accept loads main and moves to ONE; otherwise stay in EMPTY.
  - From ONE, accept and consume: main ← input, stay in ONE.
  - From ONE, accept without consume: skid ← input, move to FULL.
  - From ONE, consume without accept: move to EMPTY.
  - From ONE, neither: hold.
  - From FULL, consume: main ← skid, move to ONE. No accept is possible because `in_ready`=0.
  - From FULL, no consume: hold.
- Flush:
  - Next state is EMPTY, whatever the current state and the other inputs.
  - A beat presented in the flush cycle is dropped.
  - Payload registers need not clear. `out_wb_en` and `out_mem_r_en` read 0 because of the valid gating.
- Ordering: strict FIFO. The skid entry is never emitted before main.
- Data registers load only on the events above. There is no other enable, so idle or stalled cycles hold their value.

## Timing
- Reset, sampled at a rising `clk` with `rst`=1:
  - State EMPTY.
  - Every payload register 0.
  - Outputs the next cycle: `out_valid`=0, `in_ready`=1, `occupancy`=0, all data and control outputs 0.
- Latency: a beat accepted at edge N appears on the outputs after edge N, in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready`=1.
- A stall on MEM (`out_ready`=0) reaches `in_ready` one cycle later. The skid entry absorbs the single beat that arrives in that window.
- Boundary cases:
  - `out_ready` is ignored while `out_valid`=0.
  - `in_valid` is ignored while `in_ready`=0. EX must hold its beat, and it is not captured.
  - `rst` and `flush` together behave as reset.
  - Reset or flush in FULL discards both entries.
- No combinational path from `out_ready` to `in_ready`. `in_ready` is the registered state decode.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the `ex_mem_payload_t` packed struct, parametrised by width localparams;
  - the state enum `{S_EMPTY, S_ONE, S_FULL}`.
- One natural sub-module, `pipe_entry_reg`: a payload register with synchronous reset and load enable, instantiated twice (main, skid).
- The top level holds the state machine, the mux that selects input or skid into main, and the output gating.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `in_valid`=0.
  - Response: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_alu_result`=0.
- Streaming:
  - Stimulus: `out_ready`=1; beats with `alu_result`=0x10, 0x20, 0x30 on consecutive cycles.
  - Response: each appears exactly one cycle later, in order; `occupancy` stays 1.
- Stall and skid:
  - Stimulus: beat A=0xA accepted; `out_ready`=0; beat B=0xB presented next cycle.
  - Response: B is captured, `occupancy`=2, `in_ready`=0.
  - Then `out_ready`=1 for 2 cycles.
  - Response: outputs A then B, then `out_valid`=0.
- Flush in FULL:
  - Stimulus: `flush` pulsed while FULL, with `in_valid`=1, `in_wb_en`=1.
  - Response: next cycle `out_valid`=0, `out_wb_en`=0, `out_mem_r_en`=0, `occupancy`=0; the presented beat is not seen.
- Backpressure ignore:
  - Stimulus: in FULL, drive `in_valid`=1 with `dest`=7 for 3 cycles.
  - Response: no change to held entries or to `out_dest`.
- Mid-operation reset:
  - Stimulus: `rst`=1 while in ONE with `out_dest`=5.
  - Response: next cycle all outputs are at their reset values.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline stage registers.
// Latency: none (types and helpers only).
// Backpressure: n/a.
//
// ex_mem_payload_t documents the field order of an EX->MEM entry for the
// default widths; ex_mem_skid_reg packs its flat entry vector in this same
// order (wb_en at the MSB, dest at the LSB) so the two stay interchangeable.
package mips_pipe_pkg;

   localparam int EX_MEM_DATA_W = 32;
   localparam int EX_MEM_DEST_W = 5;

   typedef struct packed {
      logic                     wb_en;
      logic                     mem_r_en;
      logic [EX_MEM_DATA_W-1:0] alu_result;
      logic [EX_MEM_DATA_W-1:0] mem_read_value;
      logic [EX_MEM_DEST_W-1:0] dest;
   } ex_mem_payload_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } skid_state_e;

   // Width of one packed entry: two control bits, two data words, one index.
   function automatic int payload_w(input int data_w, input int dest_w);
      return 2 + 2 * data_w + dest_w;
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload register with synchronous clear and load enable.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds its value whenever load is low.
//
// Ports: clk, rst (sync, active-high, clears to 0), load, d[W], q[W].
module pipe_entry_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register built as a two-entry skid buffer with flush.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle sustained.
// Backpressure: in_ready is a registered decode of the state (low only when
//    both entries are held); the skid entry absorbs the one beat that arrives
//    while a MEM stall is still propagating to in_ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drop all held entries and any beat presented now
//   in_valid/in_ready   EX handshake; in_* payload fields
//   out_valid/out_ready MEM handshake; out_* payload of the head entry,
//                       control bits gated by out_valid
//   occupancy           number of held entries (0..2)
module ex_mem_skid_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_read_value,
   input  logic [DEST_W-1:0] in_dest,

   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r_en,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_mem_read_value,
   output logic [DEST_W-1:0] out_dest,

   output logic [1:0]        occupancy
);

   localparam int PW = payload_w(DATA_W, DEST_W);

   // Field positions inside a packed entry (same order as ex_mem_payload_t).
   localparam int WB_BIT  = PW - 1;
   localparam int MR_BIT  = PW - 2;
   localparam int ALU_LSB = DEST_W + DATA_W;
   localparam int MRV_LSB = DEST_W;

   skid_state_e    state_q;
   skid_state_e    state_d;

   logic [PW-1:0]  in_payload;
   logic [PW-1:0]  main_d;
   logic [PW-1:0]  main_q;
   logic [PW-1:0]  skid_q;

   logic           accept;
   logic           consume;
   logic           main_ld;
   logic           skid_ld;
   logic           main_sel_skid;

   assign in_payload = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_read_value, in_dest};

   // Handshake decode comes only from the state register, so there is no
   // combinational path from out_ready back to in_ready.
   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);

   assign accept  = in_valid  & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      main_ld       = 1'b0;
      skid_ld       = 1'b0;
      main_sel_skid = 1'b0;

      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               main_ld = 1'b1;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && consume) begin
               main_ld = 1'b1;
            end else if (accept) begin
               skid_ld = 1'b1;
               state_d = S_FULL;
            end else if (consume) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only the drain move is possible.
            if (consume) begin
               main_ld       = 1'b1;
               main_sel_skid = 1'b1;
               state_d       = S_ONE;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase

      // Flush wins: no loads, and both entries are abandoned. Payloads keep
      // stale data but the valid gating hides the control bits.
      if (flush) begin
         state_d = S_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   assign main_d = main_sel_skid ? skid_q : in_payload;

   pipe_entry_reg #(.W(PW)) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (main_ld),
      .d    (main_d),
      .q    (main_q)
   );

   pipe_entry_reg #(.W(PW)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_ld),
      .d    (in_payload),
      .q    (skid_q)
   );

   // A bubble must never write the register file or read memory.
   assign out_wb_en          = main_q[WB_BIT] & out_valid;
   assign out_mem_r_en       = main_q[MR_BIT] & out_valid;
   assign out_alu_result     = main_q[ALU_LSB +: DATA_W];
   assign out_mem_read_value = main_q[MRV_LSB +: DATA_W];
   assign out_dest           = main_q[DEST_W-1:0];

   always_comb begin
      occupancy = 2'd0;
      case (state_q)
         S_ONE:   occupancy = 2'd1;
         S_FULL:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed scenarios followed by random
// traffic. The reference model is a bounded queue of up to two beats; beats
// are pushed when accepted and popped by the monitor when MEM consumes them.
module tb_ex_mem_skid_reg;

   localparam int DW = 32;
   localparam int RW = 5;

   typedef struct {
      bit          wb;
      bit          mr;
      logic [31:0] alu;
      logic [31:0] mrv;
      logic [4:0]  dest;
   } beat_t;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_wb_en;
   logic          in_mem_r_en;
   logic [DW-1:0] in_alu_result;
   logic [DW-1:0] in_mem_read_value;
   logic [RW-1:0] in_dest;
   logic          out_valid;
   logic          out_ready;
   logic          out_wb_en;
   logic          out_mem_r_en;
   logic [DW-1:0] out_alu_result;
   logic [DW-1:0] out_mem_read_value;
   logic [RW-1:0] out_dest;
   logic [1:0]    occupancy;

   int total = 0;
   int bad   = 0;

   beat_t exp_q[$];
   int    held       = 0;  // number of beats the stage should be holding
   bit    started    = 0;  // first reset edge seen
   bit    fresh_regs = 0;  // payload registers still at their reset value

   ex_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_wb_en           (in_wb_en),
      .in_mem_r_en        (in_mem_r_en),
      .in_alu_result      (in_alu_result),
      .in_mem_read_value  (in_mem_read_value),
      .in_dest            (in_dest),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_wb_en          (out_wb_en),
      .out_mem_r_en       (out_mem_r_en),
      .out_alu_result     (out_alu_result),
      .out_mem_read_value (out_mem_read_value),
      .out_dest           (out_dest),
      .occupancy          (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at the clock edge, from the inputs the DUT also samples.
   always @(posedge clk) begin
      int    nxt;
      beat_t b;
      if (rst || flush) begin
         exp_q.delete();
         held = 0;
         if (rst) begin
            started    = 1;
            fresh_regs = 1;
         end
      end else if (started) begin
         nxt = held;
         if (out_ready && held > 0) nxt--;
         if (in_valid && held < 2) begin
            b.wb   = in_wb_en;
            b.mr   = in_mem_r_en;
            b.alu  = in_alu_result;
            b.mrv  = in_mem_read_value;
            b.dest = in_dest;
            exp_q.push_back(b);
            nxt++;
            fresh_regs = 0;
         end
         held = nxt;
      end
   end

   // Monitor: compare DUT outputs mid-cycle; pop the head when MEM consumes.
   always @(negedge clk) begin
      beat_t h;
      if (started) begin
         check("occupancy", 64'(occupancy), 64'(held));
         check("out_valid", 64'(out_valid), 64'(held > 0));
         check("in_ready",  64'(in_ready),  64'(held < 2));
         if (held == 0) begin
            check("bubble_wb_en",    64'(out_wb_en),    64'd0);
            check("bubble_mem_r_en", 64'(out_mem_r_en), 64'd0);
         end
         if (fresh_regs) begin
            check("reset_alu",  64'(out_alu_result),     64'd0);
            check("reset_mrv",  64'(out_mem_read_value), 64'd0);
            check("reset_dest", 64'(out_dest),           64'd0);
         end
         if (held > 0) begin
            if (exp_q.size() == 0) begin
               check("model_queue_nonempty", 64'd0, 64'd1);
            end else begin
               h = exp_q[0];
               check("head_wb_en",    64'(out_wb_en),          64'(h.wb));
               check("head_mem_r_en", 64'(out_mem_r_en),       64'(h.mr));
               check("head_alu",      64'(out_alu_result),     64'(h.alu));
               check("head_mrv",      64'(out_mem_read_value), 64'(h.mrv));
               check("head_dest",     64'(out_dest),           64'(h.dest));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Apply one cycle of stimulus and advance past the next edge.
   task automatic cyc(input bit v, input logic [31:0] alu, input logic [4:0] dest,
                      input bit wb, input bit mr, input bit ordy, input bit fl, input bit r);
      in_valid          = v;
      in_alu_result     = alu;
      in_mem_read_value = ~alu;
      in_dest           = dest;
      in_wb_en          = wb;
      in_mem_r_en       = mr;
      out_ready         = ordy;
      flush             = fl;
      rst               = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 0; in_alu_result = '0; in_mem_read_value = '0; in_dest = '0;
      in_wb_en = 0; in_mem_r_en = 0; out_ready = 0; flush = 0; rst = 1;

      // Reset then idle (out_ready toggled to show it is ignored when empty).
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Streaming at full rate.
      cyc(1, 32'h10, 5'd1, 1, 0, 1, 0, 0);
      cyc(1, 32'h20, 5'd2, 0, 1, 1, 0, 0);
      cyc(1, 32'h30, 5'd3, 1, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Stall and skid: A accepted, MEM stalls, B absorbed by skid entry.
      cyc(1, 32'hA, 5'd10, 1, 0, 0, 0, 0);
      cyc(1, 32'hB, 5'd11, 0, 1, 0, 0, 0);
      // Backpressure ignore: dest 7 held on input while FULL.
      cyc(1, 32'h77, 5'd7, 1, 1, 0, 0, 0);
      cyc(1, 32'h77, 5'd7, 1, 1, 0, 0, 0);
      cyc(1, 32'h77, 5'd7, 1, 1, 0, 0, 0);
      // Drain A then B (input idle), then empty.
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Flush in FULL with a beat presented in the flush cycle.
      cyc(1, 32'hC1, 5'd12, 1, 1, 0, 0, 0);
      cyc(1, 32'hC2, 5'd13, 1, 1, 0, 0, 0);
      cyc(1, 32'hC3, 5'd14, 1, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Mid-operation reset while ONE with dest 5; then rst+flush together.
      cyc(1, 32'h55, 5'd5, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h66, 5'd6, 1, 0, 0, 0, 0);
      cyc(1, 32'h67, 5'd8, 0, 1, 0, 0, 0);
      cyc(1, 32'h68, 5'd9, 1, 1, 1, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 4) != 0, $urandom, 5'($urandom),
             1'($urandom), 1'($urandom),
             ($urandom % 3) != 0,
             ($urandom % 50) == 0,
             ($urandom % 300) == 0);
      end

      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
